mux_tree_pipe: RTL
==================

# mux_tree_pipe

Parametrised, pipelined N-to-1 data selector with a valid/ready handshake. It replaces the fixed 32-input combinational selector used in the match/literal selection paths of the Deflate kernel. Input count, data width and pipeline depth are configurable. Selection is done as a tree of registered 4:1 levels, which keeps wide fan-in selection off the critical path at kernel clock rates while sustaining one selection per cycle.

## Interface
Parameters:
- `WIDTH`, default 8: data width per input.
- `NUM_IN`, default 32: number of inputs. Legal range is 2..256 and need not be a power of 2.
- `SEL_W`, default `$clog2(NUM_IN)`: select width. It is derived and must not be overridden.
- `LEVELS`, default `ceil(log4(NUM_IN))`: number of registered 4:1 levels, which equals the latency in cycles. It is derived. With `NUM_IN=32`, `LEVELS=3`.

Ports:
- `clk`, input, 1 bit: kernel clock. All state is on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `din`, input, `NUM_IN*WIDTH` bits: packed inputs. Input k occupies bits `[k*WIDTH +: WIDTH]`.
- `sel`, input, `SEL_W` bits: index of the input to forward.
- `in_valid`, input, 1 bit: `din` and `sel` are valid this cycle.
- `in_ready`, output, 1 bit: the pipeline accepts a beat this cycle.
- `dout`, output, `WIDTH` bits: selected data.
- `out_valid`, output, 1 bit: `dout` and `sel_err` are valid.
- `out_ready`, input, 1 bit: the downstream block accepts a beat.
- `sel_err`, output, 1 bit: the beat at the output had `sel >= NUM_IN`.

## Operation
- **Input padding:** the inputs are conceptually padded to `4^LEVELS` entries. Padding entries read as `din0`, so an out-of-range `sel` yields `din0` data with `sel_err=1`.
- **Level 1 (first registered level):**
  - Forms groups of 4 inputs. Each group selects one entry with `sel[1:0]`.
  - Registers the `4^(LEVELS-1)` group results.
  - Also registers the remaining select bits `sel[SEL_W-1:2]`, `sel_err`, and a valid bit.
- **Level i:** does the same on the previous level's results, using the next 2 select bits.
- **Final level:** holds exactly one `WIDTH` result. This register drives `dout` directly, with no logic after it.
- **Odd bit count:** when `SEL_W` is odd, the top level is a 2:1 level; its unused select bit is treated as 0.
- **Advance rule:** all levels advance together on `en = out_ready | ~out_valid`.
  - `in_ready = en`.
  - A beat is accepted when `in_valid & in_ready`.
  - When `en=1` and `in_valid=0`, a bubble (valid=0) enters level 1.
- **Stall:** when `en=0`, every level register holds its value, including the data, valid, select and error bits.
- **Sideband:** the error flag and remaining select bits travel with the data so that every beat stays self-consistent.
- **No reordering or dropping:** each accepted beat appears at the output exactly once, in acceptance order.

## Timing
- **Latency:** a beat accepted at cycle t appears with `out_valid=1` at cycle `t+LEVELS` if `out_ready` was high on every intervening cycle. Each stalled cycle adds one cycle.
- **Throughput:** 1 beat per cycle while `out_ready=1`.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready` and `out_valid` only. It does not depend on `in_valid`. There is no combinational path from `din` or `sel` to any output.
- **Output stability:** while `out_valid=1` and `out_ready=0`, `dout` and `sel_err` must not change.
- **Reset:**
  - While `rst_n=0`, all valid bits, data registers and select registers read 0.
  - Reset values: `out_valid=0`, `dout=0`, `sel_err=0`. `in_ready=1`, because `out_valid=0`.
  - Deassertion is taken synchronously at the next `clk` edge. An external synchroniser is used; there is no internal one.
  - Reset asserted mid-stream discards all in-flight beats immediately and asynchronously. No partial beat is emitted afterwards.
- **Simultaneous accept and emit:** a new input is accepted and the output beat is consumed in the same cycle with no bubble.
- **`NUM_IN=2`:** `LEVELS=1`, a single registered 2:1 level.

## Test plan
- **Reset values:**
  - Stimulus: hold `rst_n=0` for 3 cycles with random `din` and `in_valid=1`.
  - Required: `out_valid=0`, `dout=0`, `sel_err=0` and `in_ready=1` throughout.
  - Release reset; first output appears no earlier than 3 cycles after the first accepted beat.
- **Sweep, `NUM_IN=32`, `WIDTH=8`:**
  - Stimulus: `din` k = `8'hA0+k`; `sel=0..31` on consecutive cycles; `out_ready=1`.
  - Required: `dout` = `A0..BF` in order starting 3 cycles later; `out_valid` continuous for 32 cycles; `sel_err=0`.
- **Backpressure:**
  - Stimulus: the sweep above with `out_ready` toggling 1,0,0,1,...
  - Required: no beat lost or duplicated; `dout` stable while stalled; `in_ready` equals `out_ready | ~out_valid` on every cycle.
- **Out-of-range select, `NUM_IN=20`:**
  - Stimulus: `din0=8'h5A`; `sel=19` then `sel=25`.
  - Required: `dout = din19` with `sel_err=0`, then `8'h5A` with `sel_err=1`.
- **Reset mid-operation:**
  - Stimulus: 2 beats in flight; assert `rst_n=0` asynchronously between clock edges.
  - Required: `out_valid` drops to 0 immediately; neither in-flight beat ever appears after release.
- **Bubbles and `NUM_IN=2`:**
  - Stimulus: `in_valid` pattern 1,0,1 with `sel` 1,x,0, and `din1=3`, `din0=7`.
  - Required: at latency 1 the output shows `out_valid` 1,0,1 with `dout` 3,-,7.

Source files
------------

// File: rtl/mux_tree_pipe.sv
`timescale 1ns/1ps
// mux_tree_pipe: pipelined N-to-1 selector built from registered 4:1 levels,
// all levels sharing one advance enable derived from the output handshake.
module mux_tree_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 32,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int LEVELS = (SEL_W + 1) / 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);
    localparam int SW  = 2 * LEVELS;
    localparam int PAD = 1 << SW;
    localparam logic [SEL_W:0] NUM_IN_V = NUM_IN[SEL_W:0];

    logic             en;
    logic [SW-1:0]    sel_x;
    logic             err_in;
    logic [WIDTH-1:0] pad [PAD];

    // Select is zero-extended to whole 2-bit digits, so an odd-width top
    // level degenerates to a 2:1 choice.
    assign sel_x  = SW'(sel);
    assign err_in = ({1'b0, sel} >= NUM_IN_V);

    for (genvar k = 0; k < PAD; k++) begin : g_pad
        if (k < NUM_IN) begin : g_real
            assign pad[k] = din[k*WIDTH +: WIDTH];
        end else begin : g_fill
            assign pad[k] = din[WIDTH-1:0];
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int CNT = 1 << (2 * (LEVELS - 1 - l));
        localparam int RW  = 2 * (LEVELS - 1 - l);

        logic [WIDTH-1:0] src  [4*CNT];
        logic [WIDTH-1:0] nxt  [CNT];
        logic [WIDTH-1:0] data [CNT];
        logic [RW+1:0]    s_in;
        logic             v_in;
        logic             e_in;
        logic             vld;
        logic             err;

        if (l == 0) begin : g_src
            assign src  = pad;
            assign s_in = sel_x;
            assign v_in = in_valid;
            assign e_in = err_in;
        end else begin : g_src
            assign src  = g_lvl[l-1].data;
            assign s_in = g_lvl[l-1].g_rs.rsel;
            assign v_in = g_lvl[l-1].vld;
            assign e_in = g_lvl[l-1].err;
        end

        for (genvar j = 0; j < CNT; j++) begin : g_mux
            assign nxt[j] = s_in[1] ? (s_in[0] ? src[4*j+3] : src[4*j+2])
                                    : (s_in[0] ? src[4*j+1] : src[4*j]);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld  <= 1'b0;
                err  <= 1'b0;
                data <= '{default: '0};
            end else if (en) begin
                vld  <= v_in;
                err  <= e_in;
                data <= nxt;
            end
        end

        // Remaining select digits travel with the beat for the levels above.
        if (RW > 0) begin : g_rs
            logic [RW-1:0] rsel;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rsel <= '0;
                end else if (en) begin
                    rsel <= s_in[RW+1:2];
                end
            end
        end
    end

    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign out_valid = g_lvl[LEVELS-1].vld;
    assign sel_err   = g_lvl[LEVELS-1].err;
    assign dout      = g_lvl[LEVELS-1].data[0];

endmodule
